// File: rtl/div_unit_pkg.sv
// Shared definitions for the multicycle signed divider: state encoding,
// default datapath width and the most-negative operand value.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] MIN_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_SIGN = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left,
// trial-subtract the divisor, keep the difference when it is non-negative.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // One guard bit above the partial remainder makes the trial sign a plain MSB test.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {2'b00, divisor};
        rem_next = shifted[WIDTH:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            rem_next = trial[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider (DIV/DIVM): magnitudes are divided one quotient
// bit per clock, then signs are fixed up (quotient truncates, rem follows dividend).
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    logic signed [WIDTH-1:0] dividend_s;
    logic signed [WIDTH-1:0] divisor_s;

    assign dividend_s = dividend;
    assign divisor_s  = divisor;

    // MIN_NEG has no positive twin; its bit pattern read unsigned is already 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return (v[WIDTH-1] && (v != WIDTH'(MIN_NEG))) ? -v : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        unique case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                        state_d    = DIV_DONE;
                    end else begin
                        quo_d     = mag(dividend_s);
                        dvs_d     = mag(divisor_s);
                        neg_quo_d = dividend_s[WIDTH-1] ^ divisor_s[WIDTH-1];
                        neg_rem_d = dividend_s[WIDTH-1];
                        rem_d     = '0;
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        state_d   = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = DIV_SIGN;
                end
            end
            DIV_SIGN: begin
                lo_d    = neg_quo_q ? -quo_q : quo_q;
                hi_d    = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DIV_IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule
